// File: rtl/position_tracker.sv
// Multi-turn position tracker feeding the position-loop PI.
// Unwraps 12-bit single-turn angle samples into a saturating 20-bit signed
// multi-turn position and strobes the PI calculation enable every DIV updates.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_INIT | waiting for the first sample after reset (becomes zero reference)
// S_IDLE | waiting for the next sample
// S_CALC | delta registered, checking it against MAX_DELTA
// S_ACC  | accumulating delta into the position, strobing oPos_valid/oCal_en
module position_tracker #(
    parameter logic [3:0]  DIV       = 4'd10,
    parameter logic [10:0] MAX_DELTA = 11'd512
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [11:0] iAngle,
    input  logic        iAngle_valid,
    input  logic        iZero,
    input  logic        iClear_fault,
    output logic [19:0] oPosition,
    output logic        oPos_valid,
    output logic        oCal_en,
    output logic [2:0]  oFault
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_CALC = 2'd2,
        S_ACC  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] prev;
    logic [11:0] delta;
    logic [3:0]  div_cnt;

    logic [11:0] delta_mag;
    logic        overspeed;
    logic [20:0] sum;
    logic        sum_ovf;
    logic [19:0] pos_sat;
    logic        busy;
    logic        zero_hit;
    logic [2:0]  fault_set;

    // Delta magnitude check and 21-bit accumulate with clamp to the 20-bit range
    always_comb begin
        delta_mag = delta[11] ? (~delta + 12'd1) : delta;
        overspeed = (delta_mag > {1'b0, MAX_DELTA});
        sum       = {oPosition[19], oPosition} + {{9{delta[11]}}, delta};
        sum_ovf   = sum[20] ^ sum[19];
        if (sum_ovf) begin
            pos_sat = sum[20] ? 20'h80000 : 20'h7FFFF;
        end else begin
            pos_sat = sum[19:0];
        end
        busy      = (state == S_CALC) || (state == S_ACC);
        zero_hit  = iZero && (state != S_INIT);
        fault_set = 3'b000;
        fault_set[0] = (state == S_CALC) && !iZero && overspeed;
        fault_set[1] = busy && iAngle_valid && !iZero;
        fault_set[2] = (state == S_ACC) && !iZero && sum_ovf;
    end

    // State register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; iZero aborts any in-flight update
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: if (iAngle_valid) state_nxt = S_IDLE;
            S_IDLE: if (!iZero && iAngle_valid) state_nxt = S_CALC;
            S_CALC: begin
                if (iZero || overspeed) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_ACC;
                end
            end
            S_ACC:   state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    // Previous angle and registered wrap-around delta
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            prev  <= 12'd0;
            delta <= 12'd0;
        end else begin
            // Samples arriving mid-update are dropped unless iZero aborts it
            if (iAngle_valid && ((state == S_INIT) || (state == S_IDLE) || iZero)) begin
                prev <= iAngle;
            end
            // 12-bit subtraction wraps mod 4096, giving -2048..2047
            if ((state == S_IDLE) && iAngle_valid && !iZero) begin
                delta <= iAngle - prev;
            end
        end
    end

    // Position accumulator, update strobes and calculation-enable divider
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oPosition  <= 20'd0;
            oPos_valid <= 1'b0;
            oCal_en    <= 1'b0;
            div_cnt    <= 4'd0;
        end else begin
            oPos_valid <= 1'b0;
            oCal_en    <= 1'b0;
            if (zero_hit) begin
                oPosition <= 20'd0;
                div_cnt   <= 4'd0;
            end else if (state == S_ACC) begin
                oPosition  <= pos_sat;
                oPos_valid <= 1'b1;
                if (div_cnt == DIV - 4'd1) begin
                    div_cnt <= 4'd0;
                    oCal_en <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + 4'd1;
                end
            end
        end
    end

    // Sticky faults; a new fault in the clearing cycle survives the clear
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oFault <= 3'b000;
        end else begin
            oFault <= (iClear_fault ? 3'b000 : oFault) | fault_set;
        end
    end

endmodule

// File: tb/tb_position_tracker.sv
// Self-checking bench for position_tracker: reference model plus scoreboard.
module tb_position_tracker;

    localparam int DIV       = 10;
    localparam int MAX_DELTA = 512;
    localparam int POS_MAX   = 524287;
    localparam int POS_MIN   = -524288;

    logic        iClk;
    logic        iRst_n;
    logic [11:0] iAngle;
    logic        iAngle_valid;
    logic        iZero;
    logic        iClear_fault;
    logic [19:0] oPosition;
    logic        oPos_valid;
    logic        oCal_en;
    logic [2:0]  oFault;

    position_tracker dut (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .iAngle       (iAngle),
        .iAngle_valid (iAngle_valid),
        .iZero        (iZero),
        .iClear_fault (iClear_fault),
        .oPosition    (oPosition),
        .oPos_valid   (oPos_valid),
        .oCal_en      (oCal_en),
        .oFault       (oFault)
    );

    typedef struct {
        int pos;
        bit cal;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   cal_seen = 0;

    // reference model state
    bit   m_init  = 0;
    int   m_prev  = 0;
    int   m_pos   = 0;
    int   m_cnt   = 0;
    int   m_fault = 0;

    initial iClk = 0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops one expectation per oPos_valid
    always @(negedge iClk) begin
        if (iRst_n) begin
            if (oCal_en && !oPos_valid) check("cal_en_without_valid", 1, 0);
            if (oPos_valid) begin
                if (oCal_en) cal_seen++;
                if (q.size() == 0) begin
                    check("unexpected_pos_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("position", int'($signed(oPosition)), e.pos);
                    check("cal_en", int'(oCal_en), int'(e.cal));
                    check("latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    function automatic int wrap_delta(input int a, input int p);
        int d;
        d = (a - p) & 4095;
        if (d >= 2048) d -= 4096;
        return d;
    endfunction

    // Apply one accepted sample to the model; returns whether an update follows
    task automatic model_sample(input int a, input int drive_cyc);
        int d;
        exp_t e;
        if (!m_init) begin
            m_init = 1;
            m_prev = a;
            return;
        end
        d = wrap_delta(a, m_prev);
        m_prev = a;
        if (d > MAX_DELTA || d < -MAX_DELTA) begin
            m_fault |= 1;
            return;
        end
        m_pos += d;
        if (m_pos > POS_MAX) begin
            m_pos = POS_MAX;
            m_fault |= 4;
        end else if (m_pos < POS_MIN) begin
            m_pos = POS_MIN;
            m_fault |= 4;
        end
        m_cnt++;
        e.cal = (m_cnt == DIV);
        if (e.cal) m_cnt = 0;
        e.pos = m_pos;
        e.cyc = drive_cyc + 3;
        q.push_back(e);
    endtask

    task automatic send(input int a, input int gap);
        @(negedge iClk);
        iAngle       = 12'(a);
        iAngle_valid = 1;
        model_sample(a, cyc);
        @(negedge iClk);
        iAngle_valid = 0;
        repeat (gap - 2) @(negedge iClk);
    endtask

    task automatic step(input int s, input int gap);
        send((m_prev + s) & 4095, gap);
    endtask

    task automatic zero();
        @(negedge iClk);
        iZero = 1;
        m_pos = 0;
        m_cnt = 0;
        @(negedge iClk);
        iZero = 0;
    endtask

    task automatic clear_fault();
        @(negedge iClk);
        iClear_fault = 1;
        m_fault = 0;
        @(negedge iClk);
        iClear_fault = 0;
    endtask

    task automatic settle();
        repeat (5) @(negedge iClk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        iRst_n = 0; iAngle = 0; iAngle_valid = 0; iZero = 0; iClear_fault = 0;
        repeat (3) @(negedge iClk);
        check("reset_position", int'(oPosition), 0);
        check("reset_pos_valid", int'(oPos_valid), 0);
        check("reset_cal_en", int'(oCal_en), 0);
        check("reset_fault", int'(oFault), 0);
        iRst_n = 1;

        // first sample is the zero reference, second produces +50
        send(100, 4);
        check("init_position", int'($signed(oPosition)), 0);
        send(150, 4);
        settle();
        check("first_update", int'($signed(oPosition)), 50);

        // wrap-around in both directions
        send(4090, 4);
        zero();
        send(5, 4);
        settle();
        check("wrap_forward", int'($signed(oPosition)), 11);
        send(4090, 4);
        settle();
        check("wrap_backward", int'($signed(oPosition)), 0);
        for (int i = 0; i < 64; i++) step(64, 3);
        settle();
        check("full_turn", int'($signed(oPosition)), 4096);

        // divider: 25 updates after a zero give exactly two strobes
        zero();
        c0 = cal_seen;
        for (int i = 0; i < 25; i++) step(int'($urandom_range(1024, 0)) - 512, 4);
        settle();
        check("cal_count_25", cal_seen - c0, 2);

        // overspeed step
        clear_fault();
        step(600, 4);
        settle();
        check("overspeed_fault", int'(oFault), 1);
        check("overspeed_pos", int'($signed(oPosition)), m_pos);

        // overrun: two strobes one clock apart, second ignored
        @(negedge iClk);
        iAngle = 12'((m_prev + 20) & 4095);
        iAngle_valid = 1;
        model_sample((m_prev + 20) & 4095, cyc);
        @(negedge iClk);
        iAngle = 12'((m_prev + 300) & 4095);
        m_fault |= 2;
        @(negedge iClk);
        iAngle_valid = 0;
        settle();
        check("overrun_fault", int'(oFault), 3);
        step(5, 4);
        settle();
        check("overrun_prev_kept", int'($signed(oPosition)), m_pos);
        clear_fault();
        check("fault_cleared", int'(oFault), 0);

        // randomized traffic, including some overspeed steps
        for (int i = 0; i < 60; i++) step(int'($urandom_range(1400, 0)) - 700, int'($urandom_range(6, 3)));
        settle();
        check("random_fault", int'(oFault), m_fault);
        check("random_pos", int'($signed(oPosition)), m_pos);
        clear_fault();

        // positive saturation at max sample rate
        zero();
        while (m_pos < POS_MAX) step(500, 3);
        step(500, 3);
        settle();
        check("sat_pos", int'($signed(oPosition)), POS_MAX);
        check("sat_fault", int'(oFault), 4);
        step(-100, 3);
        settle();
        check("sat_release", int'($signed(oPosition)), POS_MAX - 100);
        clear_fault();

        // iZero one clock after the sample aborts the update and restarts divider
        for (int i = 0; i < 3; i++) step(7, 4);
        settle();
        @(negedge iClk);
        iAngle = 12'((m_prev + 40) & 4095);
        iAngle_valid = 1;
        m_prev = (m_prev + 40) & 4095;
        @(negedge iClk);
        iAngle_valid = 0;
        iZero = 1;
        m_pos = 0;
        m_cnt = 0;
        @(negedge iClk);
        iZero = 0;
        settle();
        check("zero_abort_pos", int'($signed(oPosition)), 0);
        c0 = cal_seen;
        for (int i = 0; i < 9; i++) step(3, 4);
        settle();
        check("zero_div_9", cal_seen - c0, 0);
        step(3, 4);
        settle();
        check("zero_div_10", cal_seen - c0, 1);

        // reset asserted while in S_ACC
        @(negedge iClk);
        iAngle = 12'((m_prev + 10) & 4095);
        iAngle_valid = 1;
        @(negedge iClk);
        iAngle_valid = 0;
        @(negedge iClk);
        #2 iRst_n = 0;
        #1;
        check("midreset_pos", int'(oPosition), 0);
        check("midreset_valid", int'(oPos_valid), 0);
        check("midreset_fault", int'(oFault), 0);
        m_init = 0; m_pos = 0; m_cnt = 0; m_fault = 0; m_prev = 0;
        @(negedge iClk);
        iRst_n = 1;
        send(300, 4);
        settle();
        check("reinit_pos", int'($signed(oPosition)), 0);
        send(310, 4);
        settle();
        check("reinit_update", int'($signed(oPosition)), 10);

        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/position_tracker.md
Name: position_tracker

Overview:
Multi-turn position tracker that sits directly upstream of the position-loop PI.
- Takes 12-bit single-turn absolute encoder angle samples and unwraps them across the 0/4095 boundary.
- Accumulates them into a 20-bit signed multi-turn position that drives the PI's current-position input.
- Produces the single-cycle calculation-enable strobe that triggers the PI at a divided update rate.

Parameters:
DIV, 4'd10, number of accepted position updates per oCal_en strobe (1..15)
MAX_DELTA, 11'd512, largest |angle step| accepted per sample; larger steps are faults

Ports:
iClk  input  1  system clock
iRst_n  input  1  asynchronous active-low reset
iAngle  input  12  unsigned single-turn angle, 4096 counts/rev
iAngle_valid  input  1  one-cycle strobe, iAngle valid this cycle
iZero  input  1  one-cycle strobe, set multi-turn position to 0
iClear_fault  input  1  one-cycle strobe, clear sticky fault bits
oPosition  output  20  signed multi-turn position, counts
oPos_valid  output  1  one-cycle strobe, oPosition updated this cycle
oCal_en  output  1  one-cycle strobe to the position-loop PI iCal_en
oFault  output  3  sticky: [0] overspeed, [1] sample overrun, [2] position saturated

Behaviour:
- Clock and reset: one clock, iClk. Reset is asynchronous and active-low on iRst_n.
- Reset values:
  - oPosition=0, oPos_valid=0, oCal_en=0, oFault=0.
  - Previous-angle register=0, divider count=0, state=S_INIT.
- State machine: S_INIT, S_IDLE, S_CALC, S_ACC.
- S_INIT: waiting for the first sample after reset.
  - On iAngle_valid: load prev=iAngle; oPosition stays 0 (power-up angle is the zero reference); go to S_IDLE.
  - No oPos_valid and no oCal_en are produced.
- S_IDLE: on iAngle_valid at edge T:
  - register delta = (iAngle - prev) taken mod 4096 as 12-bit two's complement (range -2048..2047);
  - load prev=iAngle;
  - go to S_CALC.
- S_CALC (edge T+1):
  - If |delta| > MAX_DELTA: set oFault[0], discard the sample, return to S_IDLE, no oPos_valid.
  - Else go to S_ACC.
- S_ACC (edge T+2):
  - oPosition <= sat20(oPosition + sign-extended delta), computed at 21 bits.
  - Clamp to +524287 / -524288. Any clamp sets oFault[2].
  - oPos_valid=1 for this one cycle. Increment the divider count.
  - When the count reaches DIV: oCal_en=1 for the same cycle and the count resets to 0.
  - Return to S_IDLE.
- Latency: iAngle_valid at edge T -> oPosition/oPos_valid at edge T+2. Maximum accepted sample rate is 1 per 3 clocks.
- oCal_en is asserted in the same cycle as the oPos_valid that completes the DIV-th update, so the PI samples the new position on its rising edge.
- Wrap-around example: prev=4090, iAngle=5 -> delta=+11 (not -4085). prev=5, iAngle=4090 -> delta=-11.
- Overrun: iAngle_valid while in S_CALC or S_ACC:
  - the sample is ignored (prev is not updated);
  - set oFault[1].
- iZero: in any state except S_INIT, on the cycle it is seen:
  - oPosition <= 0 and the divider count <= 0;
  - any in-flight S_CALC/S_ACC update is discarded (no oPos_valid, no oCal_en); go to S_IDLE;
  - prev is retained.
  - If iZero and iAngle_valid occur in the same cycle, iZero wins and the sample only loads prev.
  - iZero in S_INIT has no effect.
- iClear_fault clears oFault to 0. If a fault condition occurs in the same cycle, the set wins.
- Saturation holds: further steps in the saturating direction keep the clamp. Steps in the opposite direction move off the clamp normally.
- Reset asserted mid-operation: all registers return to reset values immediately. The next sample re-enters S_INIT.

Test Plan:
- Reset, then angle 100 -> no oPos_valid, oPosition=0. Then angle 150 -> oPos_valid exactly 2 clocks after the strobe, oPosition=50.
- Wrap: prev 4090, samples 5 then 4090 -> oPosition +11 then back to 0. Forward 4096-count sweep in 64-count steps -> oPosition=+4096.
- Divider, DIV=10: 25 in-range samples spaced 4 clocks -> oCal_en pulses exactly on updates 10 and 20, each 1 cycle, coincident with oPos_valid.
- Faults:
  - step of 600 counts -> oFault=3'b001, oPosition unchanged;
  - valid strobes 1 clock apart -> oFault[1] set, second sample ignored;
  - iClear_fault -> oFault=0.
- Saturation: drive oPosition to 524200 with +500 steps -> clamps at 524287 with oFault[2] set; a following -100 step -> 524187.
- iZero asserted at T+1 of an update -> no oPos_valid, oPosition=0, divider restarts (next oCal_en after 10 further updates). Reset pulse mid-S_ACC -> all outputs 0, state S_INIT.
